// File: rtl/sales_ledger_bcd.sv
// Per-product sale counters and turnover accumulator, both saturating, with a
// query path that reports one count and the turnover as packed BCD via double-dabble.
module sales_ledger_bcd #(
  parameter int unsigned N_PROD = 7,
  parameter int unsigned ID_W   = 3,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned TURN_W = 7,
  parameter int unsigned AMT_W  = 4,
  parameter int unsigned NDIG   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              sale_vld,
  input  logic [ID_W-1:0]   sale_id,
  input  logic [AMT_W-1:0]  sale_amt,
  input  logic              qry_vld,
  input  logic [ID_W-1:0]   qry_id,
  output logic              qry_rdy,
  output logic              rsp_vld,
  output logic [4*NDIG-1:0] cnt_bcd,
  output logic [4*NDIG-1:0] turn_bcd,
  output logic              ovf
);

  localparam int unsigned BCD_W = 4 * NDIG;
  localparam int unsigned IT_W  = $clog2(TURN_W + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [TURN_W-1:0] TURN_MAX = '1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt [1:N_PROD];
  logic [TURN_W-1:0]  turn;
  logic [TURN_W:0]    turn_sum;
  logic               sale_ok;
  logic [CNT_W-1:0]   qry_cnt;
  logic [IT_W-1:0]    iter;
  logic [TURN_W-1:0]  cbin, tbin;
  logic [BCD_W-1:0]   cbcd, tbcd;
  logic [BCD_W-1:0]   cadj, tadj;

  assign sale_ok  = sale_vld && (sale_id != '0) && (sale_id <= ID_W'(N_PROD));
  assign turn_sum = {1'b0, turn} + (TURN_W+1)'(sale_amt);
  assign qry_rdy  = (state == IDLE) && en;

  // Count lookup for the queried product; invalid IDs read as zero.
  always_comb begin
    qry_cnt = '0;
    for (int unsigned i = 1; i <= N_PROD; i++) begin
      if (qry_id == ID_W'(i)) qry_cnt = cnt[i];
    end
  end

  function automatic logic [BCD_W-1:0] dab_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int unsigned d = 0; d < NDIG; d++) begin
      if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign cadj = dab_adj(cbcd);
  assign tadj = dab_adj(tbcd);

  // Ledger: clr wins over a same-cycle sale; saturated values hold and flag ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i <= N_PROD; i++) cnt[i] <= '0;
      turn <= '0;
      ovf  <= 1'b0;
    end else if (clr) begin
      for (int unsigned i = 1; i <= N_PROD; i++) cnt[i] <= '0;
      turn <= '0;
      ovf  <= 1'b0;
    end else if (sale_ok) begin
      for (int unsigned i = 1; i <= N_PROD; i++) begin
        if (sale_id == ID_W'(i)) begin
          if (cnt[i] == CNT_MAX) ovf <= 1'b1;
          else                   cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      if (turn_sum > {1'b0, TURN_MAX}) begin
        turn <= TURN_MAX;
        ovf  <= 1'b1;
      end else begin
        turn <= turn_sum[TURN_W-1:0];
      end
    end
  end

  // Query FSM: snapshot on accept, TURN_W double-dabble steps, then publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      iter     <= '0;
      cbin     <= '0;
      tbin     <= '0;
      cbcd     <= '0;
      tbcd     <= '0;
      cnt_bcd  <= '0;
      turn_bcd <= '0;
      rsp_vld  <= 1'b0;
    end else begin
      rsp_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (qry_vld && qry_rdy) begin
            cbin  <= TURN_W'(qry_cnt);
            tbin  <= turn;
            cbcd  <= '0;
            tbcd  <= '0;
            iter  <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          {cbcd, cbin} <= {cadj[BCD_W-2:0], cbin, 1'b0};
          {tbcd, tbin} <= {tadj[BCD_W-2:0], tbin, 1'b0};
          iter         <= iter + IT_W'(1);
          if (iter == IT_W'(TURN_W - 1)) state <= DONE;
        end
        DONE: begin
          cnt_bcd  <= cbcd;
          turn_bcd <= tbcd;
          rsp_vld  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sales_ledger_bcd.sv
// Directed bench for sales_ledger_bcd: vector table of sale bursts and queries,
// plus hand sequences for same-edge sales, busy queries, clr and mid-conversion reset.
module tb_sales_ledger_bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic        sale_vld = 1'b0;
  logic [2:0]  sale_id = '0;
  logic [3:0]  sale_amt = '0;
  logic        qry_vld = 1'b0;
  logic [2:0]  qry_id = '0;
  logic        qry_rdy, rsp_vld, ovf;
  logic [11:0] cnt_bcd, turn_bcd;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int LAT = 8;  // steps from the accept step to rsp_vld visible

  always #5 clk = ~clk;

  sales_ledger_bcd dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .sale_vld(sale_vld), .sale_id(sale_id), .sale_amt(sale_amt),
    .qry_vld(qry_vld), .qry_id(qry_id), .qry_rdy(qry_rdy),
    .rsp_vld(rsp_vld), .cnt_bcd(cnt_bcd), .turn_bcd(turn_bcd), .ovf(ovf)
  );

  typedef struct {
    bit         do_clr;
    logic [2:0] sid;
    logic [3:0] amt;
    int         n;
    logic [2:0] qid;
    logic [11:0] ec;
    logic [11:0] et;
    bit         eo;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sale(input logic [2:0] id, input logic [3:0] amt, input int n);
    for (int k = 0; k < n; k++) begin
      sale_vld = 1'b1; sale_id = id; sale_amt = amt;
      step();
    end
    sale_vld = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_vld && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic query(input logic [2:0] id, input bit drop_en, output int lat);
    chk("qry_rdy before query", int'(qry_rdy), 1);
    qry_vld = 1'b1; qry_id = id;
    step();
    qry_vld = 1'b0;
    if (drop_en) en = 1'b0;
    wait_rsp(0, lat);
    en = 1'b1;
  endtask

  task automatic check_rsp(input string tag, input int lat, input logic [11:0] ec,
                           input logic [11:0] et, input bit eo);
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " cnt_bcd"}, int'(cnt_bcd), int'(ec));
    chk({tag, " turn_bcd"}, int'(turn_bcd), int'(et));
    chk({tag, " ovf"}, int'(ovf), int'(eo));
    step();
    chk({tag, " rsp_vld one cycle"}, int'(rsp_vld), 0);
  endtask

  task automatic count_rsp(input int cycles, output int hits);
    hits = 0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (rsp_vld) hits++;
    end
  endtask

  initial begin
    int lat;
    int hits;

    tbl[0]  = '{1'b1, 3'd2, 4'd5,  3, 3'd2, 12'h003, 12'h015, 1'b0};
    tbl[1]  = '{1'b1, 3'd4, 4'd1, 33, 3'd4, 12'h031, 12'h033, 1'b1};
    tbl[2]  = '{1'b1, 3'd1, 4'd9, 20, 3'd1, 12'h020, 12'h127, 1'b1};
    tbl[3]  = '{1'b1, 3'd0, 4'd2,  1, 3'd0, 12'h000, 12'h000, 1'b0};
    tbl[4]  = '{1'b0, 3'd7, 4'd2,  1, 3'd0, 12'h000, 12'h002, 1'b0};
    tbl[5]  = '{1'b0, 3'd7, 4'd2,  0, 3'd7, 12'h001, 12'h002, 1'b0};
    tbl[6]  = '{1'b1, 3'd3, 4'd0, 31, 3'd3, 12'h031, 12'h000, 1'b0};
    tbl[7]  = '{1'b0, 3'd3, 4'd0,  1, 3'd3, 12'h031, 12'h000, 1'b1};
    tbl[8]  = '{1'b1, 3'd5, 4'd15, 8, 3'd5, 12'h008, 12'h120, 1'b0};
    tbl[9]  = '{1'b0, 3'd5, 4'd7,  1, 3'd5, 12'h009, 12'h127, 1'b0};
    tbl[10] = '{1'b0, 3'd5, 4'd0,  1, 3'd5, 12'h010, 12'h127, 1'b0};

    // Reset state
    step(); step();
    chk("reset cnt_bcd", int'(cnt_bcd), 0);
    chk("reset turn_bcd", int'(turn_bcd), 0);
    chk("reset rsp_vld", int'(rsp_vld), 0);
    chk("reset ovf", int'(ovf), 0);
    rst_n = 1'b1;
    step();
    chk("idle qry_rdy", int'(qry_rdy), 1);

    // en low blocks acceptance; requests are not queued
    en = 1'b0;
    #1;
    chk("en=0 qry_rdy", int'(qry_rdy), 0);
    qry_vld = 1'b1; qry_id = 3'd1;
    step(); step(); step();
    qry_vld = 1'b0;
    en = 1'b1;
    count_rsp(12, hits);
    chk("en=0 no rsp", hits, 0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].do_clr) pulse_clr();
      sale(tbl[i].sid, tbl[i].amt, tbl[i].n);
      query(tbl[i].qid, 1'b0, lat);
      check_rsp($sformatf("vec%0d", i), lat, tbl[i].ec, tbl[i].et, tbl[i].eo);
    end

    // Same-edge and in-flight sales do not disturb the snapshot
    pulse_clr();
    sale(3'd1, 4'd4, 2);
    chk("pre-snap qry_rdy", int'(qry_rdy), 1);
    sale_vld = 1'b1; sale_id = 3'd1; sale_amt = 4'd4;
    qry_vld = 1'b1; qry_id = 3'd1;
    step();
    qry_vld = 1'b0;
    step();
    sale_vld = 1'b0;
    chk("conv qry_rdy", int'(qry_rdy), 0);
    qry_vld = 1'b1; qry_id = 3'd3;
    step(); step();
    qry_vld = 1'b0;
    wait_rsp(3, lat);
    check_rsp("snapshot", lat, 12'h002, 12'h008, 1'b0);
    count_rsp(12, hits);
    chk("busy query no extra rsp", hits, 0);
    query(3'd1, 1'b1, lat);
    check_rsp("post-snap en-drop", lat, 12'h004, 12'h016, 1'b0);

    // clr beats a same-edge sale and clears ovf
    sale(3'd6, 4'd15, 9);
    clr = 1'b1; sale_vld = 1'b1; sale_id = 3'd6; sale_amt = 4'd5;
    step();
    clr = 1'b0; sale_vld = 1'b0;
    query(3'd6, 1'b0, lat);
    check_rsp("clr+sale", lat, 12'h000, 12'h000, 1'b0);

    // Reset mid-conversion aborts and zeroes outputs
    sale(3'd2, 4'd3, 1);
    query(3'd2, 1'b0, lat);
    check_rsp("pre-abort", lat, 12'h001, 12'h003, 1'b0);
    qry_vld = 1'b1; qry_id = 3'd2;
    step();
    qry_vld = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("abort cnt_bcd", int'(cnt_bcd), 0);
    chk("abort turn_bcd", int'(turn_bcd), 0);
    chk("abort rsp_vld", int'(rsp_vld), 0);
    step();
    rst_n = 1'b1;
    count_rsp(12, hits);
    chk("abort no rsp", hits, 0);
    chk("abort qry_rdy", int'(qry_rdy), 1);
    query(3'd2, 1'b0, lat);
    check_rsp("post-abort", lat, 12'h000, 12'h000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
